// File: rtl/ape_stream_ctrl_if.sv
// Stream and core-side bus of the Ape stream sequencer.
// The master modport is the sequencer; the slave modport is its environment (fetch buffer, consumer, core).
interface ape_stream_ctrl_if #(
    parameter int ISA_W = 34,
    parameter int VC_W  = 16,
    parameter int KEY_W = 64
);
    logic             ct_valid_i;
    logic             ct_ready_o;
    logic [ISA_W-1:0] ct_data_i;
    logic             pt_valid_o;
    logic             pt_ready_i;
    logic [ISA_W-1:0] pt_data_o;
    logic [KEY_W-1:0] core_key_o;
    logic [ISA_W-1:0] core_ct_o;
    logic [VC_W-1:0]  core_vc_o;
    logic [ISA_W-1:0] core_prev_o;
    logic [ISA_W-1:0] core_pt_i;
    logic [VC_W-1:0]  core_vc_i;
    logic [ISA_W-1:0] core_prev_i;

    modport master (
        input  ct_valid_i, ct_data_i, pt_ready_i, core_pt_i, core_vc_i, core_prev_i,
        output ct_ready_o, pt_valid_o, pt_data_o, core_key_o, core_ct_o, core_vc_o, core_prev_o
    );

    modport slave (
        output ct_valid_i, ct_data_i, pt_ready_i, core_pt_i, core_vc_i, core_prev_i,
        input  ct_ready_o, pt_valid_o, pt_data_o, core_key_o, core_ct_o, core_vc_o, core_prev_o
    );
endinterface

// File: rtl/ape_stream_ctrl.sv
// Sequencer feeding one Ape decrypt/auth core across a block of ISA words,
// carrying the Vc/prev chaining state and checking the final Vc against the tag.
module ape_stream_ctrl #(
    parameter int ISA_W    = 34,
    parameter int VC_W     = 16,
    parameter int KEY_W    = 64,
    parameter int MAX_BLK  = 16,
    parameter int LEN_W    = 5,
    parameter int CORE_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [LEN_W-1:0] blk_len_i,
    input  logic [KEY_W-1:0] key_i,
    input  logic [VC_W-1:0]  tag_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             auth_fail_o,
    ape_stream_ctrl_if.master bus
);
    localparam int LAT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, CALC, EMIT, CHECK, DONE} state_t;

    state_t           state;
    logic [KEY_W-1:0] key;
    logic [VC_W-1:0]  tag;
    logic [VC_W-1:0]  vc;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] count;
    logic [LAT_W-1:0] lat_cnt;
    logic [ISA_W-1:0] ct;
    logic [ISA_W-1:0] prev;
    logic [ISA_W-1:0] pt;
    logic             auth_fail;
    logic [LEN_W-1:0] len_clamped;

    assign len_clamped = (blk_len_i > LEN_W'(MAX_BLK)) ? LEN_W'(MAX_BLK) : blk_len_i;

    // Stream flags and status are pure decodes of the state register.
    assign busy_o          = (state != IDLE);
    assign done_o          = (state == DONE);
    assign auth_fail_o     = auth_fail;
    assign bus.ct_ready_o  = (state == LOAD);
    assign bus.pt_valid_o  = (state == EMIT);
    assign bus.pt_data_o   = pt;
    assign bus.core_key_o  = key;
    assign bus.core_ct_o   = ct;
    assign bus.core_vc_o   = vc;
    assign bus.core_prev_o = prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            key       <= '0;
            tag       <= '0;
            vc        <= '0;
            len       <= '0;
            count     <= '0;
            lat_cnt   <= '0;
            ct        <= '0;
            prev      <= '0;
            pt        <= '0;
            auth_fail <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        key       <= key_i;
                        tag       <= tag_i;
                        len       <= len_clamped;
                        vc        <= '0;
                        prev      <= '0;
                        count     <= '0;
                        auth_fail <= 1'b0;
                        state     <= (len_clamped == '0) ? CHECK : LOAD;
                    end
                end
                LOAD: begin
                    if (bus.ct_valid_i) begin
                        ct      <= bus.ct_data_i;
                        lat_cnt <= LAT_W'(CORE_LAT - 1);
                        state   <= CALC;
                    end
                end
                CALC: begin
                    // Core inputs have been stable for CORE_LAT cycles once the counter reaches zero.
                    if (lat_cnt == '0) begin
                        pt    <= bus.core_pt_i;
                        vc    <= bus.core_vc_i;
                        prev  <= bus.core_prev_i;
                        count <= count + LEN_W'(1);
                        state <= EMIT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                EMIT: begin
                    if (bus.pt_ready_i) begin
                        state <= (count == len) ? CHECK : LOAD;
                    end
                end
                CHECK: begin
                    auth_fail <= (vc != tag);
                    state     <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ape_stream_ctrl.sv
// Scoreboard bench for ape_stream_ctrl with a one-cycle stub core:
// pt = ct ^ prev, vc_next = vc + ct[15:0], prev_next = ct.
module tb_ape_stream_ctrl;
    localparam int ISA_W = 34;
    localparam int VC_W  = 16;
    localparam int KEY_W = 64;
    localparam int LEN_W = 5;

    localparam logic [63:0] K1 = 64'h1234567890ABCDEF;
    localparam logic [63:0] K2 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] K3 = 64'hDEADBEEFCAFEF00D;

    typedef struct {
        logic [ISA_W-1:0] pt;
        logic [ISA_W-1:0] prev;
        logic [VC_W-1:0]  vc;
        logic [KEY_W-1:0] key;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [LEN_W-1:0] blk_len;
    logic [KEY_W-1:0] key;
    logic [VC_W-1:0]  tag;
    logic             busy, done, auth_fail;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   acc_cnt = 0;
    int   pt_cnt = 0;
    exp_t sb[$];

    ape_stream_ctrl_if #(.ISA_W(ISA_W), .VC_W(VC_W), .KEY_W(KEY_W)) bus ();

    ape_stream_ctrl #(
        .ISA_W(ISA_W), .VC_W(VC_W), .KEY_W(KEY_W),
        .MAX_BLK(16), .LEN_W(LEN_W), .CORE_LAT(1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .blk_len_i   (blk_len),
        .key_i       (key),
        .tag_i       (tag),
        .busy_o      (busy),
        .done_o      (done),
        .auth_fail_o (auth_fail),
        .bus         (bus)
    );

    // Stub core
    assign bus.core_pt_i   = bus.core_ct_o ^ bus.core_prev_o;
    assign bus.core_vc_i   = bus.core_vc_o + bus.core_ct_o[15:0];
    assign bus.core_prev_i = bus.core_ct_o;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [ISA_W-1:0] p, input logic [ISA_W-1:0] pv,
                        input logic [VC_W-1:0] v, input logic [KEY_W-1:0] k);
        exp_t e;
        e.pt = p; e.prev = pv; e.vc = v; e.key = k;
        sb.push_back(e);
    endtask

    // Monitor: inputs only change just after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) done_cnt++;
            if (bus.ct_valid_i && bus.ct_ready_o) acc_cnt++;
            if (bus.pt_valid_o && bus.pt_ready_i) begin
                pt_cnt++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_pt", 64'(bus.pt_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_pt",   64'(bus.pt_data_o),   64'(e.pt));
                    check("sb_prev", 64'(bus.core_prev_o), 64'(e.prev));
                    check("sb_vc",   64'(bus.core_vc_o),   64'(e.vc));
                    check("sb_key",  bus.core_key_o,       e.key);
                end
            end
        end
    end

    task automatic start_blk(input int len, input logic [KEY_W-1:0] k, input logic [VC_W-1:0] t);
        start = 1'b1; blk_len = LEN_W'(len); key = k; tag = t;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_ct(input logic [ISA_W-1:0] d, input int gap);
        logic rdy;
        int   n;
        repeat (gap) begin @(posedge clk); #1; end
        bus.ct_valid_i = 1'b1;
        bus.ct_data_i  = d;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.ct_ready_o;
            @(posedge clk); #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("ct_handshake_timeout", 64'(n), 64'(0));
        bus.ct_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input logic exp_fail);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_done_timeout"}, 64'(n), 64'(0));
        else check({name, "_auth_fail"}, 64'(auth_fail), 64'(exp_fail));
        @(posedge clk); #1;
    endtask

    initial begin
        logic [ISA_W-1:0] ct4 [9];
        logic [ISA_W-1:0] pt4 [9];
        logic [VC_W-1:0]  vc4 [9];
        logic [ISA_W-1:0] hold, pv;
        logic [VC_W-1:0]  rv;
        int d0, a0, p0, n;

        ct4 = '{34'h0f37b80e1, 34'h05a000003, 34'h0f37b20e0, 34'h01800a003, 34'h0f17ba0e0,
                34'h01a002103, 34'h0f37bf1e1, 34'h04000b101, 34'h0737ba0e0};
        pt4 = '{34'h0f37b80e1, 34'h0a97b80e2, 34'h0a97b20e3, 34'h0eb7b80e3, 34'h0e97b00e3,
                34'h0eb7b81e3, 34'h0e97bd0e2, 34'h0b37b40e0, 34'h0337b11e1};
        vc4 = '{16'h80e1, 16'h80e4, 16'ha1c4, 16'h41c7, 16'he2a7,
                16'h03aa, 16'hf58b, 16'ha68c, 16'h476c};

        rst_n = 1'b0; start = 1'b0; blk_len = '0; key = '0; tag = '0;
        bus.ct_valid_i = 1'b0; bus.ct_data_i = '0; bus.pt_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        check("rst_auth", 64'(auth_fail), 0);
        check("rst_ct_ready", 64'(bus.ct_ready_o), 0);
        check("rst_pt_valid", 64'(bus.pt_valid_o), 0);
        check("rst_pt_data", 64'(bus.pt_data_o), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic pass
        d0 = done_cnt;
        push(34'h11, 34'h11, 16'h0011, K1);
        push(34'h33, 34'h22, 16'h0033, K1);
        start_blk(2, K1, 16'h0033);
        check("t1_busy", 64'(busy), 1);
        send_ct(34'h11, 0);
        @(posedge clk); #1;
        check("t1_pt_latency", 64'(bus.pt_valid_o), 1);
        send_ct(34'h22, 0);
        wait_done("t1", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_done_once", 64'(done_cnt - d0), 1);

        // 2: tag mismatch, sticky fail
        push(34'h11, 34'h11, 16'h0011, K1);
        push(34'h33, 34'h22, 16'h0033, K1);
        start_blk(2, K1, 16'h0034);
        send_ct(34'h11, 0);
        send_ct(34'h22, 0);
        wait_done("t2", 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("t2_fail_sticky", 64'(auth_fail), 1);
        check("t2_idle", 64'(busy), 0);

        // 3: backpressure on pt, gaps on ct
        bus.pt_ready_i = 1'b0;
        push(34'h11, 34'h11, 16'h0011, K1);
        push(34'h33, 34'h22, 16'h0033, K1);
        start_blk(2, K1, 16'h0033);
        check("t3_fail_cleared", 64'(auth_fail), 0);
        send_ct(34'h11, 3);
        n = 0;
        @(negedge clk);
        while (!bus.pt_valid_o && n < 20) begin @(negedge clk); n++; end
        check("t3_pt_valid", 64'(bus.pt_valid_o), 1);
        hold = bus.pt_data_o;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t3_pt_stable", 64'(bus.pt_data_o), 64'(hold));
            check("t3_ct_ready_low", 64'(bus.ct_ready_o), 0);
        end
        @(posedge clk); #1;
        bus.pt_ready_i = 1'b1;
        send_ct(34'h22, 3);
        wait_done("t3", 1'b0);

        // 4: full nine-word block
        p0 = pt_cnt;
        start_blk(9, K1, 16'h476c);
        for (int i = 0; i < 9; i++) begin
            push(pt4[i], ct4[i], vc4[i], K1);
            send_ct(ct4[i], 0);
        end
        wait_done("t4", 1'b0);
        check("t4_pt_count", 64'(pt_cnt - p0), 9);
        check("t4_key_held", bus.core_key_o, K1);

        // 5a: empty block
        a0 = acc_cnt;
        bus.ct_valid_i = 1'b1; bus.ct_data_i = 34'h3ff;
        start_blk(0, K2, 16'h0000);
        @(posedge clk); #1;
        check("t5a_done", 64'(done), 1);
        check("t5a_auth", 64'(auth_fail), 0);
        bus.ct_valid_i = 1'b0;
        @(posedge clk); #1;
        check("t5a_no_ct", 64'(acc_cnt - a0), 0);

        // 5b: oversize length clamps to 16, mid-block start ignored
        a0 = acc_cnt; p0 = pt_cnt; pv = '0; rv = '0;
        start_blk(31, K2, 16'h0088);
        for (int i = 1; i <= 16; i++) begin
            logic [ISA_W-1:0] c;
            c = ISA_W'(i);
            rv = rv + c[15:0];
            push(c ^ pv, c, rv, K2);
            pv = c;
            send_ct(c, 0);
            if (i == 5) begin
                start_blk(0, K3, 16'h0000);
            end
        end
        bus.ct_valid_i = 1'b1; bus.ct_data_i = 34'h2aa;
        wait_done("t5b", 1'b0);
        bus.ct_valid_i = 1'b0;
        @(posedge clk); #1;
        check("t5b_ct_count", 64'(acc_cnt - a0), 16);
        check("t5b_pt_count", 64'(pt_cnt - p0), 16);

        // 6: reset during CALC of word 3
        d0 = done_cnt;
        push(34'h11, 34'h11, 16'h0011, K1);
        push(34'h33, 34'h22, 16'h0033, K1);
        start_blk(4, K1, 16'h0033);
        send_ct(34'h11, 0);
        send_ct(34'h22, 0);
        send_ct(34'h44, 0);
        check("t6_in_calc", 64'({busy, bus.pt_valid_o, bus.ct_ready_o}), 64'(3'b100));
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 0);
        check("t6_done", 64'(done), 0);
        check("t6_auth", 64'(auth_fail), 0);
        check("t6_ready_valid", 64'({bus.ct_ready_o, bus.pt_valid_o}), 0);
        check("t6_pt_data", 64'(bus.pt_data_o), 0);
        check("t6_core_regs", 64'(bus.core_ct_o | bus.core_prev_o | 34'(bus.core_vc_o)), 0);
        check("t6_core_key", bus.core_key_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(34'h11, 34'h11, 16'h0011, K1);
        push(34'h33, 34'h22, 16'h0033, K1);
        start_blk(2, K1, 16'h0033);
        send_ct(34'h11, 0);
        send_ct(34'h22, 0);
        wait_done("t6", 1'b0);
        check("t6_done_once", 64'(done_cnt - d0), 1);

        repeat (3) @(posedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ape_stream_ctrl.md
Name: ape_stream_ctrl

Overview:
Sequencer that drives one Ape decryption/authentication core across a block of 34-bit encrypted ISA words.
- Accepts ciphertext words over a valid/ready stream and presents each word to the core.
- Holds the chaining state (Vc, prevISA) between words and returns plaintext over a valid/ready stream.
- At block end, compares the final chaining value with the expected tag and reports pass or fail.
- Sits between the instruction fetch buffer and the Ape core, replacing manual per-cycle feedback of vc/prev latches.

Parameters:
ISA_W, 34, instruction/ciphertext word width
VC_W, 16, chaining value and tag width
KEY_W, 64, key width
MAX_BLK, 16, maximum words per block
LEN_W, 5, width of blk_len_i (must hold MAX_BLK)
CORE_LAT, 1, core latency in cycles from stable inputs to valid outputs (>=1)

Ports:
clk_i  in  1  clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  begin block; sampled only in IDLE
blk_len_i  in  LEN_W  words in block
key_i  in  KEY_W  block key, latched at start
tag_i  in  VC_W  expected tag, latched at start
busy_o  out  1  high in any state except IDLE
done_o  out  1  one-cycle pulse at block completion
auth_fail_o  out  1  result of last block; sticky until next accepted start
ct_valid_i  in  1  ciphertext valid
ct_ready_o  out  1  ciphertext ready
ct_data_i  in  ISA_W  ciphertext word
pt_valid_o  out  1  plaintext valid
pt_ready_i  in  1  plaintext ready
pt_data_o  out  ISA_W  plaintext word
core_key_o  out  KEY_W  to core
core_ct_o  out  ISA_W  to core (registered)
core_vc_o  out  VC_W  chaining value to core
core_prev_o  out  ISA_W  previous-word state to core
core_pt_i  in  ISA_W  core plaintext
core_vc_i  in  VC_W  core next chaining value
core_prev_i  in  ISA_W  core next prev state

Behaviour:
- Reset (async, any state): FSM=IDLE. All registers zero: key, tag, len, count, ct, vc, prev, pt_data_o. All outputs 0 (busy_o, done_o, auth_fail_o, ct_ready_o, pt_valid_o).
- States: IDLE, LOAD, CALC, EMIT, CHECK, DONE.
- IDLE + start_i:
  - Latch key_i, tag_i and len. len = blk_len_i, clamped to MAX_BLK if larger.
  - Clear vc and prev to 0, clear count and auth_fail_o.
  - Next state LOAD, or CHECK if len==0.
- LOAD: ct_ready_o=1 (combinational from state). On ct_valid_i&ct_ready_o, register ct_data_i into core_ct_o, load the latency counter with CORE_LAT-1, go CALC.
- CALC: counter decrements each cycle. On the edge where the counter is 0:
  - capture core_pt_i into pt_data_o;
  - capture core_vc_i into vc and core_prev_i into prev;
  - count += 1; go EMIT.
  - Result: pt_valid_o rises exactly CORE_LAT cycles after the ct handshake edge.
- EMIT: pt_valid_o=1 and pt_data_o held stable until pt_ready_i. On handshake go CHECK if count==len, else LOAD.
- Throughput: one word per CORE_LAT+2 cycles when both streams are always ready.
- CHECK (one cycle): auth_fail_o <= (vc != tag). Go DONE.
- DONE (one cycle): done_o=1, go IDLE.
- len==0: no data accepted. CHECK compares vc=0 with the tag, so the block passes only if tag==0.
- core_key_o, core_vc_o and core_prev_o are driven continuously from the registers. They are stable throughout CALC.
- start_i while busy: ignored, with no effect on latched values.
- ct_valid_i outside LOAD: ignored; word not consumed.
- Plaintext is released before authentication completes. Consumers must discard the block on auth_fail_o.
- Reset mid-block: immediate return to IDLE with all state cleared. A partially emitted block gets no done_o.

Test Plan:
(All scenarios use a bench stub core: pt = ct ^ prev, vc_next = vc + ct[15:0], prev_next = ct, with CORE_LAT=1.)
1. Basic pass: len=2, tag=0x0033, ct 0x11 then 0x22 → pt 0x11 then 0x33; done_o pulses once; auth_fail_o=0; pt_valid_o one cycle after each ct handshake.
2. Tag mismatch: same stream, tag=0x0034 → identical plaintext; auth_fail_o=1 from the DONE cycle until the next start.
3. Backpressure: pt_ready_i held low 5 cycles in EMIT → pt_data_o stable, ct_ready_o=0 throughout, no word lost. ct_valid_i gaps of 3 cycles → stall in LOAD only.
4. Full block: len=9 with ciphertexts 0xf37b80e1, 0x5a000003, 0xf37b20e0, 0x1800a003, 0xf17ba0e0, 0x1a002103, 0xf37bf1e1, 0x4000b101, 0x737ba0e0; key 0x1234567890ABCDEF → exactly 9 pt handshakes. Key/vc/prev seen by the stub match the expected chaining model; core_key_o stays 0x1234567890ABCDEF.
5. Boundaries: len=0, tag=0 → done_o 2 cycles after start, auth_fail_o=0, no ct accepted. blk_len_i=31 → exactly 16 words processed. start_i pulsed mid-block → ignored.
6. Reset: assert rst_ni low during CALC of word 3 → all outputs 0 immediately. After release, a new len=2 block yields pt 0x11, 0x33 (vc/prev restarted from 0).
